// File: rtl/ethpipe_rx_slot_ctrl.sv
// rtl/ethpipe_rx_slot_ctrl.sv - RX slot ring controller between GMII receiver handshake and host.
// Define ETHPIPE_RX_IRQ_COALESCE_EN for threshold/timeout irq coalescing.
module ethpipe_rx_slot_ctrl #(
  parameter int unsigned SLOT_BITS   = 2,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned IRQ_THRESH  = 3,
  parameter logic [15:0] IRQ_TIMEOUT = 16'd1024
) (
  input  logic                 pci_clk,
  input  logic                 sys_rst_n,
  input  logic                 rx_complete,
  output logic                 rx_empty,
  output logic [SLOT_BITS-1:0] rx_wr_slot,
  output logic [SLOT_BITS-1:0] host_rd_slot,
  output logic [SLOT_BITS:0]   host_avail,
  input  logic                 host_release,
  input  logic                 irq_mask,
  input  logic                 irq_ack,
  output logic                 irq,
  output logic                 rel_err,
  output logic [15:0]          drop_cnt
);

  localparam int unsigned        NSLOT     = 2 ** SLOT_BITS;
  localparam logic [SLOT_BITS:0] CNT_FULL  = (SLOT_BITS + 1)'(NSLOT);
  localparam int unsigned        HOLD_W    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {W_READY, W_HOLD, W_FULL} wstate_t;

  wstate_t            wstate;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [SLOT_BITS:0] cnt_nxt;
  logic               full, empty, acc_wr, acc_rd;
  logic               pend, pend_nxt;

  always_comb begin
    full    = (host_avail == CNT_FULL);
    empty   = (host_avail == '0);
    acc_wr  = rx_complete && !full;
    acc_rd  = host_release && !empty;
    cnt_nxt = host_avail;
    if (acc_wr && !acc_rd)
      cnt_nxt = host_avail + 1'b1;
    else if (acc_rd && !acc_wr)
      cnt_nxt = host_avail - 1'b1;
  end

  // Ring pointers, occupancy and error/drop bookkeeping
  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_wr_slot   <= '0;
      host_rd_slot <= '0;
      host_avail   <= '0;
      drop_cnt     <= '0;
      rel_err      <= 1'b0;
    end else begin
      host_avail <= cnt_nxt;
      if (acc_wr)
        rx_wr_slot <= rx_wr_slot + 1'b1;
      if (acc_rd)
        host_rd_slot <= host_rd_slot + 1'b1;
      if (rx_complete && full && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      if (host_release && empty)
        rel_err <= 1'b1;
      else if (irq_ack)
        rel_err <= 1'b0;
    end
  end

  // Reset lands in W_HOLD so the receiver sees rx_empty only after the sync window
  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wstate   <= W_HOLD;
      hold_cnt <= HOLD_LOAD;
      rx_empty <= 1'b0;
    end else if (acc_wr) begin
      wstate   <= W_HOLD;
      hold_cnt <= HOLD_LOAD;
      rx_empty <= 1'b0;
    end else begin
      case (wstate)
        W_READY: rx_empty <= 1'b1;
        W_HOLD: begin
          if (hold_cnt == '0) begin
            if (!full) begin
              wstate   <= W_READY;
              rx_empty <= 1'b1;
            end else begin
              wstate <= W_FULL;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        W_FULL: begin
          if (!full) begin
            wstate   <= W_READY;
            rx_empty <= 1'b1;
          end
        end
        default: begin
          wstate   <= W_HOLD;
          hold_cnt <= HOLD_LOAD;
          rx_empty <= 1'b0;
        end
      endcase
    end
  end

`ifdef ETHPIPE_RX_IRQ_COALESCE_EN
  localparam logic [15:0] TMO_LAST = IRQ_TIMEOUT - 16'd1;

  logic [15:0] timer, timer_nxt;

  always_comb begin
    timer_nxt = timer;
    pend_nxt  = pend;
    if (irq_ack) begin
      timer_nxt = '0;
      pend_nxt  = 1'b0;
    end else begin
      if (empty)
        timer_nxt = '0;
      else if (!pend && timer != TMO_LAST)
        timer_nxt = timer + 16'd1;
      if (32'(cnt_nxt) >= IRQ_THRESH || (!empty && !pend && timer == TMO_LAST))
        pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      timer <= '0;
    else
      timer <= timer_nxt;
  end
`else
  // ack_q lets pend re-arm one cycle after an ack that left frames in the ring
  logic ack_q;

  always_comb begin
    pend_nxt = pend | acc_wr | (ack_q && !empty);
    if (irq_ack)
      pend_nxt = 1'b0;
  end

  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      ack_q <= 1'b0;
    else
      ack_q <= irq_ack;
  end
`endif

  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend <= 1'b0;
      irq  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      irq  <= pend_nxt & ~irq_mask;
    end
  end

endmodule

// File: tb/tb_ethpipe_rx_slot_ctrl.sv
// tb/tb_ethpipe_rx_slot_ctrl.sv - directed scoreboard bench for ethpipe_rx_slot_ctrl.
module tb_ethpipe_rx_slot_ctrl;

  logic        pci_clk = 1'b0;
  logic        sys_rst_n;
  logic        rx_complete, host_release, irq_mask, irq_ack;
  logic        rx_empty, irq, rel_err;
  logic [1:0]  rx_wr_slot, host_rd_slot;
  logic [2:0]  host_avail;
  logic [15:0] drop_cnt;

  int tests_run = 0;
  int fails     = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  ethpipe_rx_slot_ctrl dut (
    .pci_clk      (pci_clk),
    .sys_rst_n    (sys_rst_n),
    .rx_complete  (rx_complete),
    .rx_empty     (rx_empty),
    .rx_wr_slot   (rx_wr_slot),
    .host_rd_slot (host_rd_slot),
    .host_avail   (host_avail),
    .host_release (host_release),
    .irq_mask     (irq_mask),
    .irq_ack      (irq_ack),
    .irq          (irq),
    .rel_err      (rel_err),
    .drop_cnt     (drop_cnt)
  );

  always #5 pci_clk = ~pci_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pci_clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests_run++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: observed %0h, expected a queued value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic pulse_rx();
    rx_complete = 1'b1;
    tick();
    rx_complete = 1'b0;
  endtask

  task automatic pulse_rel();
    host_release = 1'b1;
    tick();
    host_release = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    logic seen;
    sys_rst_n    = 1'b0;
    rx_complete  = 1'b0;
    host_release = 1'b0;
    irq_mask     = 1'b0;
    irq_ack      = 1'b0;
    repeat (2) tick();

    expect_val("rst_rx_empty", 0);
    expect_val("rst_wr_slot", 0);
    expect_val("rst_rd_slot", 0);
    expect_val("rst_avail", 0);
    expect_val("rst_irq", 0);
    expect_val("rst_rel_err", 0);
    expect_val("rst_drop", 0);
    check(32'(rx_empty));
    check(32'(rx_wr_slot));
    check(32'(host_rd_slot));
    check(32'(host_avail));
    check(32'(irq));
    check(32'(rel_err));
    check(32'(drop_cnt));

    sys_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      seen = seen | rx_empty;
    end
    expect_val("hold_rx_empty_low", 0);
    check(32'(seen));
    tick();
    expect_val("hold_rx_empty_rise", 1);
    check(32'(rx_empty));
    expect_val("idle_irq", 0);
    check(32'(irq));

    for (int k = 1; k <= 4; k++) begin
      expect_val("fill_wr_slot", 32'(k % 4));
      expect_val("fill_avail", 32'(k));
      expect_val("fill_rx_empty", 0);
      pulse_rx();
      check(32'(rx_wr_slot));
      check(32'(host_avail));
      check(32'(rx_empty));
`ifndef ETHPIPE_RX_IRQ_COALESCE_EN
      if (k == 1) begin
        expect_val("irq_per_frame", 1);
        check(32'(irq));
      end
`endif
      repeat (19) tick();
      expect_val("fill_rx_empty_later", (k < 4) ? 32'd1 : 32'd0);
      check(32'(rx_empty));
    end

    expect_val("drop_cnt", 1);
    expect_val("drop_avail", 4);
    expect_val("drop_wr_slot", 0);
    pulse_rx();
    check(32'(drop_cnt));
    check(32'(host_avail));
    check(32'(rx_wr_slot));

    expect_val("rel_rd_slot", 1);
    expect_val("rel_avail", 3);
    expect_val("rel_rx_empty_n1", 0);
    pulse_rel();
    check(32'(host_rd_slot));
    check(32'(host_avail));
    check(32'(rx_empty));
    expect_val("rel_rx_empty_n2", 1);
    tick();
    check(32'(rx_empty));

    pulse_rel();
    expect_val("both_avail", 2);
    expect_val("both_wr_slot", 1);
    expect_val("both_rd_slot", 3);
    rx_complete  = 1'b1;
    host_release = 1'b1;
    tick();
    rx_complete  = 1'b0;
    host_release = 1'b0;
    check(32'(host_avail));
    check(32'(rx_wr_slot));
    check(32'(host_rd_slot));

    pulse_rel();
    pulse_rel();
    expect_val("drain_avail", 0);
    check(32'(host_avail));

    expect_val("relerr_set", 1);
    expect_val("relerr_rd_slot", 1);
    expect_val("relerr_avail", 0);
    pulse_rel();
    check(32'(rel_err));
    check(32'(host_rd_slot));
    check(32'(host_avail));

    expect_val("irq_before_ack", 1);
    check(32'(irq));
    expect_val("ack_rel_err", 0);
    expect_val("ack_irq", 0);
    pulse_ack();
    check(32'(rel_err));
    check(32'(irq));
    tick();
    expect_val("ack_irq_stays", 0);
    check(32'(irq));

`ifndef ETHPIPE_RX_IRQ_COALESCE_EN
    expect_val("frame_irq", 1);
    pulse_rx();
    check(32'(irq));
    expect_val("ack_clears_irq", 0);
    pulse_ack();
    check(32'(irq));
    expect_val("irq_rearm", 1);
    tick();
    check(32'(irq));
    irq_mask = 1'b1;
    expect_val("mask_irq", 0);
    tick();
    check(32'(irq));
    irq_mask = 1'b0;
    expect_val("unmask_irq", 1);
    tick();
    check(32'(irq));
    pulse_rel();
    pulse_ack();
    tick();
    expect_val("empty_ack_irq", 0);
    check(32'(irq));
`else
    expect_val("tmo_avail", 1);
    pulse_rx();
    check(32'(host_avail));
    seen = 1'b0;
    for (int i = 0; i < 1023; i++) begin
      tick();
      seen = seen | irq;
    end
    expect_val("tmo_irq_early", 0);
    check(32'(seen));
    tick();
    expect_val("tmo_irq_fire", 1);
    check(32'(irq));
    pulse_rel();
    pulse_ack();
    tick();
    expect_val("tmo_ack_irq", 0);
    check(32'(irq));

    pulse_rx();
    expect_val("thr_irq_2", 0);
    pulse_rx();
    check(32'(irq));
    expect_val("thr_irq_3", 1);
    expect_val("thr_avail", 3);
    pulse_rx();
    check(32'(irq));
    check(32'(host_avail));

    expect_val("thr_ack_irq", 0);
    pulse_ack();
    check(32'(irq));
    expect_val("thr_rearm", 1);
    tick();
    check(32'(irq));

    irq_mask = 1'b1;
    expect_val("mask_irq", 0);
    tick();
    check(32'(irq));
    expect_val("mask_irq_hold", 0);
    repeat (3) tick();
    check(32'(irq));
    irq_mask = 1'b0;
    expect_val("unmask_irq", 1);
    tick();
    check(32'(irq));
`endif

    pulse_rx();
    sys_rst_n = 1'b0;
    #1;
    expect_val("async_rst_avail", 0);
    expect_val("async_rst_wr_slot", 0);
    expect_val("async_rst_irq", 0);
    expect_val("async_rst_rx_empty", 0);
    check(32'(host_avail));
    check(32'(rx_wr_slot));
    check(32'(irq));
    check(32'(rx_empty));

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
